// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcode constants, instruction field positions and decode helpers
package decode_pkg;

   localparam int NREG = 8;
   localparam int AW   = 3;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_DIV  = 6'b100001;
   localparam logic [5:0] NOP_OP  = 6'b010000;

   localparam int OP_HI = 15;
   localparam int OP_LO = 10;
   localparam int RD_HI = 9;
   localparam int RD_LO = 7;
   localparam int RS_HI = 6;
   localparam int RS_LO = 4;
   localparam int RT_HI = 3;
   localparam int RT_LO = 1;
   localparam int IMM_W = 7;

   function automatic logic is_legal(input logic [5:0] op);
      case (op) inside
         [6'd0:6'd2], [6'd4:6'd10], [6'd12:6'd17], [6'd20:6'd30], 6'd32, 6'd33: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic writes_rd(input logic [5:0] op);
      return is_legal(op) && ((op[5:4] == 2'b00) || (op == 6'd22) ||
                              (op >= 6'd25 && op <= 6'd27) || (op == 6'd32) || (op == 6'd33));
   endfunction

   function automatic logic is_imm(input logic [5:0] op);
      return op[5:3] == 3'b001;
   endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// rtl/decode_stage_regfile.sv - 8x16 register file, two async reads, one sync write, R0 hardwired to 0
module regfile_8x16
   import decode_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] ra_addr,
   output logic [15:0]   ra_data,
   input  logic [AW-1:0] rb_addr,
   output logic [15:0]   rb_data,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [15:0]   wd
);

   logic [15:0] mem [NREG];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else if (we && wa != '0) begin
         mem[wa] <= wd;
      end
   end

   assign ra_data = (ra_addr == '0) ? 16'h0000 : mem[ra_addr];
   assign rb_data = (rb_addr == '0) ? 16'h0000 : mem[rb_addr];

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode / operand fetch with forwarding and a one-cycle load-use style interlock
module decode_stage
   import decode_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic [15:0]   instr,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [15:0]   alu_result,
   input  logic          wb_en,
   input  logic [AW-1:0] wb_addr,
   input  logic [15:0]   wb_data,
   output logic [5:0]    op_dec,
   output logic [15:0]   A,
   output logic [15:0]   B,
   output logic [AW-1:0] rd_ex,
   output logic          wr_ex,
   output logic          illegal_op
);

   logic [5:0]    op;
   logic [AW-1:0] rd, rs, rt, ra, rb;
   logic [15:0]   ra_data, rb_data, opnd_a, opnd_b;
   logic          imm, legal, stall, issue, wr_next;
   logic [AW-1:0] d1, d2;
   logic          v1, v2;

   regfile_8x16 u_rf (
      .clk     (clk),
      .reset   (reset),
      .ra_addr (ra),
      .ra_data (ra_data),
      .rb_addr (rb),
      .rb_data (rb_data),
      .we      (wb_en),
      .wa      (wb_addr),
      .wd      (wb_data)
   );

   always_comb begin
      op    = instr[OP_HI:OP_LO];
      rd    = instr[RD_HI:RD_LO];
      rs    = instr[RS_HI:RS_LO];
      rt    = instr[RT_HI:RT_LO];
      imm   = is_imm(op);
      legal = is_legal(op);
      ra    = imm ? rd : rs;
      rb    = rt;

      // Only the instruction issued last edge can't be forwarded yet; its result appears next cycle.
      stall = instr_valid && v1 &&
              ((ra != '0 && ra == d1) || (!imm && rb != '0 && rb == d1));
      instr_ready = !stall;
      issue       = instr_valid && !stall;
      wr_next     = issue && legal && writes_rd(op) && (rd != '0);

      if (ra != '0 && v2 && ra == d2)           opnd_a = alu_result;
      else if (ra != '0 && wb_en && wb_addr == ra) opnd_a = wb_data;
      else                                      opnd_a = ra_data;

      if (imm)                                  opnd_b = {{(16-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
      else if (rb != '0 && v2 && rb == d2)      opnd_b = alu_result;
      else if (rb != '0 && wb_en && wb_addr == rb) opnd_b = wb_data;
      else                                      opnd_b = rb_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_dec     <= NOP_OP;
         A          <= '0;
         B          <= '0;
         rd_ex      <= '0;
         wr_ex      <= 1'b0;
         illegal_op <= 1'b0;
         d1         <= '0;
         v1         <= 1'b0;
         d2         <= '0;
         v2         <= 1'b0;
      end else begin
         if (issue && legal) begin
            op_dec <= op;
            A      <= opnd_a;
            B      <= opnd_b;
            rd_ex  <= rd;
         end else begin
            op_dec <= NOP_OP;
            A      <= '0;
            B      <= '0;
            rd_ex  <= '0;
         end
         wr_ex      <= wr_next;
         illegal_op <= issue && !legal;
         d1         <= wr_next ? rd : '0;
         v1         <= wr_next;
         d2         <= d1;
         v2         <= v1;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed scoreboard bench for decode_stage
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] alu_result;
   logic        wb_en;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic [5:0]  op_dec;
   logic [15:0] A, B;
   logic [2:0]  rd_ex;
   logic        wr_ex;
   logic        illegal_op;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [5:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  rd;
      logic        wr;
      logic        ill;
      logic        full;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   decode_stage dut (
      .clk         (clk),
      .reset       (reset),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .alu_result  (alu_result),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .op_dec      (op_dec),
      .A           (A),
      .B           (B),
      .rd_ex       (rd_ex),
      .wr_ex       (wr_ex),
      .illegal_op  (illegal_op)
   );

   function automatic logic [15:0] mk(input logic [5:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] rt);
      return {op, rd, rs, rt, 1'b0};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_op(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] rd, input logic wr);
      exp_t e;
      e.op = op; e.a = a; e.b = b; e.rd = rd; e.wr = wr; e.ill = 1'b0; e.full = 1'b1;
      sb.push_back(e);
   endtask

   task automatic push_bubble(input logic ill);
      exp_t e;
      e.op = 6'b010000; e.a = '0; e.b = '0; e.rd = '0; e.wr = 1'b0; e.ill = ill; e.full = 1'b0;
      sb.push_back(e);
   endtask

   task automatic chk1(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      checks++;
      assert (sb.size() > 0) else begin
         errors++;
         $error("FAIL %s: observed empty scoreboard expected entry", tag);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk1({tag, ".op_dec"}, {10'd0, op_dec}, {10'd0, e.op});
         chk1({tag, ".wr_ex"}, {15'd0, wr_ex}, {15'd0, e.wr});
         chk1({tag, ".illegal_op"}, {15'd0, illegal_op}, {15'd0, e.ill});
         if (e.full) begin
            chk1({tag, ".A"}, A, e.a);
            chk1({tag, ".B"}, B, e.b);
            chk1({tag, ".rd_ex"}, {13'd0, rd_ex}, {13'd0, e.rd});
         end
      end
   endtask

   initial begin
      reset = 1'b1; instr = '0; instr_valid = 1'b0; alu_result = 16'hDEAD;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      step(); step();
      reset = 1'b0;
      step();
      push_op(6'b010000, 16'h0, 16'h0, 3'd0, 1'b0);
      check_out("reset");
      chk1("reset.instr_ready", {15'd0, instr_ready}, 16'd1);
      step();
      push_bubble(1'b0);
      check_out("idle");

      wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h0005; step();
      wb_addr = 3'd2; wb_data = 16'h0003; step();
      wb_en = 1'b0;

      instr = mk(6'b000000, 3'd3, 3'd1, 3'd2); instr_valid = 1'b1; #1;
      chk1("add.instr_ready", {15'd0, instr_ready}, 16'd1);
      push_op(6'b000000, 16'h0005, 16'h0003, 3'd3, 1'b1);
      step(); check_out("add");

      instr = mk(6'b000001, 3'd4, 3'd3, 3'd1); #1;
      chk1("stall.instr_ready", {15'd0, instr_ready}, 16'd0);
      push_bubble(1'b0);
      step(); check_out("stall_bubble");
      alu_result = 16'h0008; #1;
      chk1("resume.instr_ready", {15'd0, instr_ready}, 16'd1);
      push_op(6'b000001, 16'h0008, 16'h0005, 3'd4, 1'b1);
      step(); check_out("sub_fwd");
      instr_valid = 1'b0; alu_result = 16'hDEAD;

      wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h1234; step();
      wb_en = 1'b0; step();
      instr = {6'b001000, 3'd5, 7'h7F}; instr_valid = 1'b1;
      push_op(6'b001000, 16'h1234, 16'hFFFF, 3'd5, 1'b1);
      step(); check_out("imm_neg");
      instr = {6'b001000, 3'd1, 7'h3F};
      push_op(6'b001000, 16'h0005, 16'h003F, 3'd1, 1'b1);
      step(); check_out("imm_pos");
      instr_valid = 1'b0; step(); step();

      wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'hABCD;
      instr = mk(6'b000000, 3'd6, 3'd1, 3'd2); instr_valid = 1'b1;
      push_op(6'b000000, 16'h0005, 16'hABCD, 3'd6, 1'b1);
      step(); check_out("wb_bypass");
      wb_addr = 3'd0; wb_data = 16'hFFFF;
      instr = mk(6'b000000, 3'd7, 3'd0, 3'd2);
      push_op(6'b000000, 16'h0000, 16'hABCD, 3'd7, 1'b1);
      step(); check_out("wb_r0_bypass");
      wb_en = 1'b0;
      instr = mk(6'b000000, 3'd0, 3'd0, 3'd0);
      push_op(6'b000000, 16'h0000, 16'h0000, 3'd0, 1'b0);
      step(); check_out("r0_read_rd0");

      instr = mk(6'b000011, 3'd3, 3'd1, 3'd2);
      push_bubble(1'b1);
      step(); check_out("illegal");
      instr_valid = 1'b0;
      push_bubble(1'b0);
      step(); check_out("illegal_pulse_end");
      step();

      instr = mk(6'b000000, 3'd3, 3'd1, 3'd2); instr_valid = 1'b1;
      push_op(6'b000000, 16'h0005, 16'hABCD, 3'd3, 1'b1);
      step(); check_out("add2");
      instr = mk(6'b000001, 3'd4, 3'd3, 3'd1); #1;
      chk1("stall2.instr_ready", {15'd0, instr_ready}, 16'd0);
      reset = 1'b1;
      push_op(6'b010000, 16'h0, 16'h0, 3'd0, 1'b0);
      step(); check_out("reset_mid_stall");
      reset = 1'b0; #1;
      chk1("post_reset.instr_ready", {15'd0, instr_ready}, 16'd1);
      push_op(6'b000001, 16'h0000, 16'h0000, 3'd4, 1'b1);
      step(); check_out("after_reset_sub");
      instr_valid = 1'b0;
      step();

      chk1("scoreboard_empty", 16'(sb.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode / operand-fetch stage; sits directly upstream of the alu block.
- Accepts 16-bit instructions and holds the 8x16 register file.
- Resolves operands through forwarding or a one-cycle interlock.
- Drives registered op_dec, A and B into the alu each cycle.
- Receives register writeback from the downstream stage.

Parameters:
NREG, 8, number of architectural registers (address width 3)
NOP_OP, 6'b010000, opcode issued as a bubble (alu holds ans_ex, flags 00)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
instr  input  16  instruction: [15:10] op, [9:7] rd, [6:4] rs, [3:1] rt, [6:0] imm7
instr_valid  input  1  instr is valid this cycle
instr_ready  output  1  instr is consumed at this edge when instr_valid && instr_ready
alu_result  input  16  alu ans_ex (registered result of the instruction issued two cycles earlier)
wb_en  input  1  register-file write enable
wb_addr  input  3  write address
wb_data  input  16  write data
op_dec  output  6  registered opcode to the alu
A  output  16  registered operand A
B  output  16  registered operand B
rd_ex  output  3  registered destination of the issued instruction
wr_ex  output  1  issued instruction writes rd_ex
illegal_op  output  1  registered one-cycle pulse: undefined opcode was replaced by NOP_OP

Behaviour:
- One clock domain (clk). reset is synchronous and active-high. On reset:
  - R0..R7 = 0, op_dec = NOP_OP, A = B = 0, rd_ex = 0.
  - wr_ex = 0, illegal_op = 0, hazard tracking cleared, instr_ready = 1 from the next cycle.
- Reset asserted mid-stall drops the pending instruction; upstream must re-present it.
- Legal opcodes:
  - 000000-000010, 000100-000111, 001000-001010, 001100-001111
  - 010000, 010001, 010100-010111, 011000-011110, 100000, 100001
- Any other opcode issues NOP_OP with wr_ex = 0 and pulses illegal_op.
- Writers of rd: ALU ops 0000xx/0001xx/0010xx/0011xx (legal only), 010110, 011001-011011, 100000, 100001. All other legal ops have wr_ex = 0.
- Immediate class, op[5:3] == 001:
  - A = R[rd], B = sign_extend(imm7) to 16 bits.
  - Source set = {rd}.
- All other ops:
  - A = R[rs], B = R[rt].
  - Source set = {rs, rt}.
- R0 reads as 0 and is never a hazard. Writes to R0 are ignored; wr_ex is forced 0 when rd = 0.
- Hazard tracking:
  - d1/v1 = destination/write flag of the instruction issued last edge.
  - d2/v2 = the one issued the edge before that.
  - Bubbles carry v = 0.
- Interlock:
  - If instr_valid and any source == d1 with v1 = 1, instr_ready = 0 this cycle.
  - The stage issues NOP_OP (wr_ex = 0) and shifts the bubble into d1.
  - The instruction is re-evaluated next cycle; a stall therefore lasts exactly 1 cycle.
- Per-operand source priority:
  1. alu_result, if source == d2 && v2.
  2. wb_data, if wb_en && wb_addr == source && source != 0 (same-cycle write bypass).
  3. Register file.
- Writeback contract: the downstream stage must assert wb for an instruction issued at edge c no later than cycle c+3.
- Register file writes on the clk edge when wb_en && wb_addr != 0. The write is independent of stall and bubble.
- instr_valid = 0 with no stall issues NOP_OP.
- Latency: instruction accepted at edge c has its op_dec, A and B visible in cycle c+1. No back-to-back stall is possible.
- Sustained throughput is 1 instruction/cycle absent hazards.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams (OP_ADD = 6'b000000 ... OP_DIV = 6'b100001), NOP_OP
  - field bit positions
  - functions is_legal(op), writes_rd(op), is_imm(op)
- One sub-module: regfile_8x16, with 2 async read ports, 1 sync write port, R0 hardwired to 0, synchronous reset clear.

Test Plan:
- Reset, then idle: after reset, op_dec = 6'b010000, A = B = 0, wr_ex = 0, instr_ready = 1; holds while instr_valid = 0.
- wb R1 = 16'h0005 and R2 = 16'h0003, then issue add rd=3, rs=1, rt=2 (op 000000) -> next cycle op_dec = 000000, A = 5, B = 3, rd_ex = 3, wr_ex = 1.
- Back-to-back dependent: add R3 then sub rd=4, rs=3 -> instr_ready = 0 for 1 cycle, NOP issued; next cycle A = alu_result (drive 16'h0008), B = R[rt].
- Immediate op 001000, rd=5, imm7 = 7'h7F -> A = R5, B = 16'hFFFF; imm7 = 7'h3F -> B = 16'h003F.
- Same-cycle wb_en, wb_addr = 2, wb_data = 16'hABCD with instr reading rt = 2 -> B = 16'hABCD. wb_addr = 0 -> R0 stays 0.
- op 6'b000011 -> op_dec = NOP_OP, wr_ex = 0, illegal_op pulses 1 cycle. Reset asserted during a stall -> outputs at reset values next cycle.
